// File: rtl/jtframe_shram_pkg.sv
// jtframe_shram_pkg
// Shared definitions for the N-channel time-shared RAM arbiter:
// FSM state encodings, arbitration mode constants, maximum channel count
// and a wrap-around index helper.

package jtframe_shram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HOLD  = 2'd2
   } shram_st_t;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;
   localparam int NCH_MAX    = 4;

   // Index of the channel following idx, wrapping at nch.
   function automatic logic [1:0] next_idx(input logic [1:0] idx, input int nch);
      int n;
      n = int'(idx) + 1;
      if (n >= nch) begin
         n = 0;
      end else begin
         n = n;
      end
      return 2'(n);
   endfunction

endpackage

// File: rtl/jtframe_arb_pick.sv
// jtframe_arb_pick
// Combinational winner selection among NCH requesters.
// Ports: req [NCH-1:0] requests, ptr [1:0] round-robin start index,
//        win [1:0] winning channel, any = at least one request.
// RR=MODE_RR: first request at or after ptr (wrapping); otherwise lowest index.

module jtframe_arb_pick
   import jtframe_shram_pkg::*;
#(
   parameter int NCH = 2,
   parameter int RR  = MODE_RR
)(
   input  logic [NCH-1:0] req,
   input  logic [1:0]     ptr,
   output logic [1:0]     win,
   output logic           any
);

   logic [NCH_MAX-1:0] req_x_s;
   logic [1:0]         idx_s;
   int                 start_s;

   // Scan offsets from the farthest down to zero so the request closest to
   // the start index is the last assignment and therefore wins.
   always_comb begin
      req_x_s          = {NCH_MAX{1'b0}};
      req_x_s[NCH-1:0] = req;
      any              = |req;
      win              = 2'd0;
      idx_s            = 2'd0;
      if (RR == MODE_RR) begin
         start_s = int'(ptr) % NCH;
      end else begin
         start_s = 0;
      end
      for (int k = NCH - 1; k >= 0; k--) begin
         idx_s = 2'((start_s + k) % NCH);
         win   = req_x_s[idx_s] ? idx_s : win;
      end
   end

endmodule

// File: rtl/jtframe_ram.sv
// jtframe_ram
// Single-port RAM, synchronous write, asynchronous read.
// Ports: clk, cen (clock enable), we (write strobe), addr [aw-1:0],
//        data [dw-1:0] write data, q [dw-1:0] read data at addr.

module jtframe_ram #(
   parameter int aw = 13,
   parameter int dw = 8
)(
   input  logic          clk,
   input  logic          cen,
   input  logic          we,
   input  logic [aw-1:0] addr,
   input  logic [dw-1:0] data,
   output logic [dw-1:0] q
);

   logic [dw-1:0] mem_r [0:(2**aw)-1];

   // Write port; contents are never cleared, so they survive a reset.
   always_ff @(posedge clk) begin
      if (cen && we) begin
         mem_r[addr] <= data;
      end
   end

   assign q = mem_r[addr];

endmodule

// File: rtl/jtframe_shram_arb.sv
// jtframe_shram_arb
// N-channel time-shared RAM with per-channel wait generation.
// Ports: clk; rst_n (synchronous, active-low);
//        ch_en/ch_cs/ch_we [NCH-1:0]; ch_addr [NCH*AW-1:0]; ch_din [NCH*DW-1:0];
//        ch_waitn [NCH-1:0] active-low waits (combinational);
//        dout [DW-1:0] shared read data; owner [1:0] current owner; busy.
// An access goes IDLE -> SETUP (RAM addressed, owner waits) -> HOLD (owner
// released, data registered every cycle). Releases hand over directly to the
// next requester without an idle cycle.

module jtframe_shram_arb
   import jtframe_shram_pkg::*;
#(
   parameter int NCH = 2,
   parameter int AW  = 13,
   parameter int DW  = 8,
   parameter int RR  = MODE_RR
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    ch_en,
   input  logic [NCH-1:0]    ch_cs,
   input  logic [NCH-1:0]    ch_we,
   input  logic [NCH*AW-1:0] ch_addr,
   input  logic [NCH*DW-1:0] ch_din,
   output logic [NCH-1:0]    ch_waitn,
   output logic [DW-1:0]     dout,
   output logic [1:0]        owner,
   output logic              busy
);

   shram_st_t          state_r, state_s;
   logic [1:0]         owner_r, owner_s;
   logic [1:0]         ptr_r, ptr_s;
   logic [NCH_MAX-1:0] req_s, wr_s;
   logic [1:0]         win_s;
   logic               any_s;
   logic [AW-1:0]      ram_addr_s;
   logic [DW-1:0]      ram_din_s, ram_q_s, dout_r;
   logic               ram_we_s;

   // Requests and write strobes qualified by enable, padded so a 2-bit owner indexes safely.
   always_comb begin
      req_s = {NCH_MAX{1'b0}};
      wr_s  = {NCH_MAX{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         req_s[i] = ch_cs[i] & ch_en[i];
         wr_s[i]  = ch_cs[i] & ch_en[i] & ch_we[i];
      end
   end

   jtframe_arb_pick #(.NCH(NCH), .RR(RR)) u_pick (
      .req (req_s[NCH-1:0]),
      .ptr (ptr_r),
      .win (win_s),
      .any (any_s)
   );

   // Next-state logic: grant from IDLE, keep while the owner requests, hand over on release.
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      ptr_s   = ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (any_s) begin
               state_s = ST_SETUP;
               owner_s = win_s;
               ptr_s   = next_idx(win_s, NCH);
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP, ST_HOLD: begin
            if (req_s[owner_r]) begin
               state_s = ST_HOLD;
            end else if (any_s) begin
               // owner is not requesting, so the winner is always another channel
               state_s = ST_SETUP;
               owner_s = win_s;
               ptr_s   = next_idx(win_s, NCH);
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // RAM port driven live from the owner's bus; writes gated by enable and reset.
   always_comb begin
      ram_addr_s = {AW{1'b0}};
      ram_din_s  = {DW{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         ram_addr_s = (owner_r == 2'(i)) ? ch_addr[i*AW +: AW] : ram_addr_s;
         ram_din_s  = (owner_r == 2'(i)) ? ch_din[i*DW +: DW]  : ram_din_s;
      end
      ram_we_s = rst_n & (state_r != ST_IDLE) & wr_s[owner_r];
   end

   // Wait generation: only the owner in HOLD and non-requesters are let through.
   always_comb begin
      ch_waitn = {NCH{1'b1}};
      for (int i = 0; i < NCH; i++) begin
         ch_waitn[i] = ~rst_n | ~req_s[i] |
                       ((state_r == ST_HOLD) & (owner_r == 2'(i)));
      end
   end

   // State, owner, round-robin pointer and read-data registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         owner_r <= 2'd0;
         ptr_r   <= 2'd0;
         dout_r  <= {DW{1'b0}};
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         ptr_r   <= ptr_s;
         if (state_r != ST_IDLE) begin
            dout_r <= ram_q_s;
         end else begin
            dout_r <= dout_r;
         end
      end
   end

   jtframe_ram #(.aw(AW), .dw(DW)) u_ram (
      .clk  (clk),
      .cen  (1'b1),
      .we   (ram_we_s),
      .addr (ram_addr_s),
      .data (ram_din_s),
      .q    (ram_q_s)
   );

   assign dout  = dout_r;
   assign owner = owner_r;
   assign busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_jtframe_shram_arb.sv
// tb_jtframe_shram_arb
// Directed bench: a two-channel round-robin instance for latency, contention,
// enable masking and reset; two four-channel instances (round-robin and fixed)
// for grant ordering.

module tb_jtframe_shram_arb;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // two-channel instance
   logic [1:0]  en_a, cs_a, we_a, waitn_a, owner_a;
   logic [25:0] addr_a;
   logic [15:0] din_a;
   logic [7:0]  dout_a;
   logic        busy_a;

   // four-channel instances: index 0 round-robin, index 1 fixed priority
   logic [3:0] cs4    [2];
   logic [3:0] waitn4 [2];
   logic [7:0] dout4  [2];
   logic [1:0] owner4 [2];
   logic       busy4  [2];

   jtframe_shram_arb #(.NCH(2), .AW(13), .DW(8), .RR(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ch_en(en_a), .ch_cs(cs_a), .ch_we(we_a),
      .ch_addr(addr_a), .ch_din(din_a), .ch_waitn(waitn_a), .dout(dout_a),
      .owner(owner_a), .busy(busy_a)
   );

   jtframe_shram_arb #(.NCH(4), .AW(13), .DW(8), .RR(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .ch_en(4'hF), .ch_cs(cs4[0]), .ch_we(4'h0),
      .ch_addr(52'd0), .ch_din(32'd0), .ch_waitn(waitn4[0]), .dout(dout4[0]),
      .owner(owner4[0]), .busy(busy4[0])
   );

   jtframe_shram_arb #(.NCH(4), .AW(13), .DW(8), .RR(0)) dut_fx (
      .clk(clk), .rst_n(rst_n), .ch_en(4'hF), .ch_cs(cs4[1]), .ch_we(4'h0),
      .ch_addr(52'd0), .ch_din(32'd0), .ch_waitn(waitn4[1]), .dout(dout4[1]),
      .owner(owner4[1]), .busy(busy4[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // One complete access on the two-channel instance; returns dout seen in HOLD.
   task automatic acc_a(input int ch, input logic w, input logic [12:0] a,
                        input logic [7:0] d, output logic [7:0] q);
      cs_a[ch]             = 1'b1;
      we_a[ch]             = w;
      addr_a[ch*13 +: 13]  = a;
      din_a[ch*8 +: 8]     = d;
      cyc();
      for (int k = 0; k < 10 && waitn_a[ch] !== 1'b1; k++) cyc();
      chk("acc_grant", 32'(waitn_a[ch]), 32'd1);
      q        = dout_a;
      cs_a[ch] = 1'b0;
      we_a[ch] = 1'b0;
      cyc();
   endtask

   logic [7:0] q;
   int hc   [2][4];
   int glog [2][5];
   int gn   [2];
   int exp_order [2][5];

   initial begin
      exp_order[0] = '{0, 1, 2, 3, 0};
      exp_order[1] = '{0, 1, 0, 1, 0};
      gn[0] = 0;
      gn[1] = 0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4; i++) begin
            hc[d][i]   = 0;
            glog[d][i] = 0;
         end
      glog[0][4] = 0;
      glog[1][4] = 0;

      // reset with requests asserted
      en_a = 2'b11; cs_a = 2'b11; we_a = 2'b00; addr_a = 26'd0; din_a = 16'd0;
      cs4[0] = 4'h0; cs4[1] = 4'h0;
      cyc(); cyc();
      chk("rst_busy",  32'(busy_a),  32'd0);
      chk("rst_waitn", 32'(waitn_a), 32'h3);
      chk("rst_owner", 32'(owner_a), 32'd0);
      chk("rst_dout",  32'(dout_a),  32'h00);
      cs_a  = 2'b00;
      rst_n = 1'b1;
      cyc();

      // preload: ch1 writes 0x5A @0x0123, ch0 writes 0x3C @0x1FFF
      acc_a(1, 1'b1, 13'h0123, 8'h5A, q);
      acc_a(0, 1'b1, 13'h1FFF, 8'h3C, q);

      // uncontested read latency
      addr_a[12:0] = 13'h0123;
      cs_a = 2'b01;
      #1;
      chk("t1_idle_waitn", 32'(waitn_a), 32'h2);
      cyc();
      chk("t1_setup_waitn", 32'(waitn_a[0]), 32'd0);
      chk("t1_setup_busy",  32'(busy_a),     32'd1);
      chk("t1_setup_owner", 32'(owner_a),    32'd0);
      cyc();
      chk("t1_hold_waitn", 32'(waitn_a[0]), 32'd1);
      chk("t1_hold_dout",  32'(dout_a),     32'h5A);

      // ch1 requests while ch0 holds
      cs_a = 2'b11;
      addr_a[25:13] = 13'h1FFF;
      #1;
      chk("t2_contend_waitn", 32'(waitn_a), 32'h1);
      cyc();
      chk("t2_still_waitn", 32'(waitn_a), 32'h1);
      chk("t2_still_owner", 32'(owner_a), 32'd0);
      cs_a = 2'b10;
      cyc();
      chk("t2_handover_owner", 32'(owner_a),    32'd1);
      chk("t2_handover_busy",  32'(busy_a),     32'd1);
      chk("t2_handover_waitn", 32'(waitn_a[1]), 32'd0);
      cyc();
      chk("t2_hold_waitn", 32'(waitn_a[1]), 32'd1);
      chk("t2_hold_dout",  32'(dout_a),     32'h3C);
      cs_a = 2'b00;
      cyc();
      chk("t2_idle_busy", 32'(busy_a), 32'd0);

      // disabled channel write is ignored
      en_a = 2'b01; cs_a = 2'b10; we_a = 2'b10;
      addr_a[25:13] = 13'h1FFF; din_a[15:8] = 8'hA5;
      #1;
      chk("t4_dis_waitn", 32'(waitn_a[1]), 32'd1);
      cyc();
      chk("t4_dis_busy", 32'(busy_a), 32'd0);
      cyc();
      cs_a = 2'b00; we_a = 2'b00; en_a = 2'b11;
      cyc();
      acc_a(0, 1'b0, 13'h1FFF, 8'h00, q);
      chk("t4_blocked_data", 32'(q), 32'h3C);
      acc_a(1, 1'b1, 13'h1FFF, 8'hA5, q);
      acc_a(0, 1'b0, 13'h1FFF, 8'h00, q);
      chk("t4_written_data", 32'(q), 32'hA5);

      // simultaneous request from IDLE, pointer at 1 after ch0's grant
      cs_a = 2'b11; we_a = 2'b00;
      addr_a = {13'h0123, 13'h0123};
      #1;
      chk("t6_idle_waitn", 32'(waitn_a), 32'h0);
      cyc();
      chk("t6_owner",       32'(owner_a), 32'd1);
      chk("t6_setup_waitn", 32'(waitn_a), 32'h0);
      cyc();
      chk("t6_hold_waitn", 32'(waitn_a), 32'h2);
      chk("t6_hold_dout",  32'(dout_a),  32'h5A);
      cs_a = 2'b01;
      cyc();
      chk("t6_next_owner", 32'(owner_a), 32'd0);
      chk("t6_next_waitn", 32'(waitn_a), 32'h2);

      // reset during ch0 HOLD
      cyc();
      chk("t5_hold_waitn", 32'(waitn_a), 32'h3);
      chk("t5_hold_busy",  32'(busy_a),  32'd1);
      cs_a  = 2'b11;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_waitn", 32'(waitn_a), 32'h3);
      cyc();
      chk("t5_rst_busy",   32'(busy_a),  32'd0);
      chk("t5_rst_waitn2", 32'(waitn_a), 32'h3);
      chk("t5_rst_dout",   32'(dout_a),  32'h00);
      chk("t5_rst_owner",  32'(owner_a), 32'd0);
      rst_n = 1'b1;
      cs_a  = 2'b00;
      cyc();
      acc_a(0, 1'b0, 13'h0123, 8'h00, q);
      chk("t5_keep_0123", 32'(q), 32'h5A);
      acc_a(1, 1'b0, 13'h1FFF, 8'h00, q);
      chk("t5_keep_1FFF", 32'(q), 32'hA5);

      // four channels request continuously, each dropping cs after 3 HOLD cycles
      for (int c = 0; c < 80 && (gn[0] < 5 || gn[1] < 5); c++) begin
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
               if (cs4[d][i] == 1'b0) begin
                  cs4[d][i] = 1'b1;
                  hc[d][i]  = 0;
               end else if (waitn4[d][i] == 1'b1) begin
                  if (hc[d][i] == 0 && gn[d] < 5) begin
                     glog[d][gn[d]] = i;
                     gn[d]++;
                  end
                  hc[d][i]++;
                  if (hc[d][i] == 3) cs4[d][i] = 1'b0;
               end
            end
         end
         cyc();
      end
      chk("t3_rr_grants", 32'(gn[0]), 32'd5);
      chk("t3_fx_grants", 32'(gn[1]), 32'd5);
      for (int g = 0; g < 5; g++) begin
         chk($sformatf("t3_rr_order%0d", g), 32'(glog[0][g]), 32'(exp_order[0][g]));
         chk($sformatf("t3_fx_order%0d", g), 32'(glog[1][g]), 32'(exp_order[1][g]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
